// File: rtl/csr_access_unit.sv
// Multicycle Zicsr executor: reads a CSR, computes the new value, conditionally
// writes it back and returns the old value to the register-file writeback path.
module csr_access_unit #(
    parameter int XLEN     = 32,
    parameter bit RO_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [11:0]     csr,
    output logic            csr_w,
    output logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] csr_rd,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rs1f_q, rs1f_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rdf_q, rdf_d;
    logic [XLEN-1:0] rs1v_q, rs1v_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;
    logic [11:0]     csr_q, csr_d;
    logic            csr_w_q, csr_w_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            rd_we_q, rd_we_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic            legal_s;
    logic [XLEN-1:0] src_s;
    logic [XLEN-1:0] new_s;
    logic            do_wr_s;
    logic            ro_viol_s;

    // Decode legality of the incoming instruction and the read-modify-write datapath.
    always_comb begin
        legal_s = (instr[6:0] == 7'b1110011) && (instr[13:12] != 2'b00);
        if (f3_q[2] == 1'b0) begin
            src_s = rs1v_q;
        end else begin
            src_s = {{(XLEN-5){1'b0}}, rs1f_q};
        end
        case (f3_q[1:0])
            2'b01: begin
                new_s   = src_s;
                do_wr_s = 1'b1;
            end
            2'b10: begin
                new_s   = csr_rd | src_s;
                do_wr_s = (rs1f_q != 5'd0);
            end
            2'b11: begin
                new_s   = csr_rd & ~src_s;
                do_wr_s = (rs1f_q != 5'd0);
            end
            default: begin
                new_s   = csr_rd;
                do_wr_s = 1'b0;
            end
        endcase
        ro_viol_s = RO_CHECK && do_wr_s && (addr_q[11:10] == 2'b11);
    end

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rs1f_d    = rs1f_q;
        f3_d      = f3_q;
        rdf_d     = rdf_q;
        rs1v_d    = rs1v_q;
        old_d     = old_q;
        csr_d     = csr_q;
        wd_d      = wd_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        csr_w_d   = 1'b0;
        rd_we_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = instr[31:20];
                    rs1f_d = instr[19:15];
                    f3_d   = instr[14:12];
                    rdf_d  = instr[11:7];
                    rs1v_d = rs1_val;
                    if (legal_s) begin
                        state_d = S_READ;
                        csr_d   = instr[31:20];
                    end else begin
                        state_d   = S_ERR;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                old_d = csr_rd;
                if (ro_viol_s) begin
                    state_d   = S_ERR;
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_WRITE;
                    wd_d    = new_s;
                    csr_w_d = do_wr_s;
                end
            end
            S_WRITE: begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                rd_we_d   = (rdf_q != 5'd0);
                rd_addr_d = rdf_q;
                rd_data_d = old_q;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, latched instruction fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 12'd0;
            rs1f_q    <= 5'd0;
            f3_q      <= 3'd0;
            rdf_q     <= 5'd0;
            rs1v_q    <= {XLEN{1'b0}};
            old_q     <= {XLEN{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            csr_q     <= 12'd0;
            csr_w_q   <= 1'b0;
            wd_q      <= {XLEN{1'b0}};
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rs1f_q    <= rs1f_d;
            f3_q      <= f3_d;
            rdf_q     <= rdf_d;
            rs1v_q    <= rs1v_d;
            old_q     <= old_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            csr_q     <= csr_d;
            csr_w_q   <= csr_w_d;
            wd_q      <= wd_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign csr     = csr_q;
    assign csr_w   = csr_w_q;
    assign wd      = wd_q;
    assign rd_we   = rd_we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

endmodule
